// File: rtl/picnic_uart_pkg.sv
// Shared UART constants, bit-timing helper and transfer FSM encoding for the picnic UART paths.
// Pure definitions: no logic, no latency, no flow control.
package picnic_uart_pkg;

  localparam int FRAME_BITS  = 10;
  localparam int SIGMA_BYTES = 2704;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_SEND,
    ST_DONE,
    ST_HOLD
  } xfer_state_e;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_shift.sv
// 8N1 serialiser: a load starts the start bit on the next cycle; each bit lasts CPB cycles.
// ld_rdy is high when idle or in the final stop-bit cycle, so frames can be chained with no gap.
module uart_tx_shift
  import picnic_uart_pkg::*;
#(
  parameter int CPB = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld_vld,
  input  logic [7:0] ld_dat,
  output logic       ld_rdy,
  output logic       frame_end,
  output logic       txd
);

  localparam int BW = (CPB > 1) ? $clog2(CPB) : 1;

  logic          busy_q, busy_d;
  logic          txd_q, txd_d;
  logic [8:0]    sh_q, sh_d;
  logic [3:0]    bit_q, bit_d;
  logic [BW-1:0] baud_q, baud_d;
  logic          bit_end, last;

  always_comb begin
    bit_end   = busy_q && (baud_q == BW'(CPB - 1));
    last      = bit_end && (bit_q == 4'(FRAME_BITS - 1));
    ld_rdy    = !busy_q || last;
    frame_end = last;
    busy_d    = busy_q;
    txd_d     = txd_q;
    sh_d      = sh_q;
    bit_d     = bit_q;
    baud_d    = baud_q;
    if (ld_vld && ld_rdy) begin
      busy_d = 1'b1;
      txd_d  = 1'b0;
      sh_d   = {1'b1, ld_dat};
      bit_d  = 4'd0;
      baud_d = '0;
    end else if (last) begin
      busy_d = 1'b0;
      txd_d  = 1'b1;
    end else if (bit_end) begin
      // Shift ones in behind the data so the stop bit falls out naturally.
      txd_d  = sh_q[0];
      sh_d   = {1'b1, sh_q[8:1]};
      bit_d  = bit_q + 4'd1;
      baud_d = '0;
    end else if (busy_q) begin
      baud_d = baud_q + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      txd_q  <= 1'b1;
      sh_q   <= '1;
      bit_q  <= 4'd0;
      baud_q <= '0;
    end else begin
      busy_q <= busy_d;
      txd_q  <= txd_d;
      sh_q   <= sh_d;
      bit_q  <= bit_d;
      baud_q <= baud_d;
    end
  end

  assign txd = txd_q;

endmodule

// File: rtl/ram_to_uart_tx.sv
// Streams BYTE_CNT bytes from RAM addr 0.. out as back-to-back 8N1 frames; first start bit RD_LAT+2 cycles after start.
// No backpressure: the next byte is prefetched into a hold register during the current frame.
module ram_to_uart_tx
  import picnic_uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200,
  parameter int ADDR_W   = 15,
  parameter int BYTE_CNT = SIGMA_BYTES,
  parameter int RD_LAT   = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_rdata,
  output logic              uart_txd,
  output logic              busy,
  output logic              done
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int LW  = $clog2(BYTE_CNT + 1);

  xfer_state_e       state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LW-1:0]     left_q, left_d;
  logic              pf_req_q, pf_req_d;
  logic [7:0]        hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic [RD_LAT-1:0] rpipe_q, rpipe_d;
  logic              rvld;
  logic              ld_vld, ld_rdy, frame_end;
  logic [7:0]        ld_dat;

  assign rvld = rpipe_q[RD_LAT-1];

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_en_d    = 1'b0;
    addr_d     = addr_q;
    left_d     = left_q;
    pf_req_d   = 1'b0;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    // Tracks each issued read so its data is captured exactly RD_LAT cycles later.
    rpipe_d    = (rpipe_q << 1) | RD_LAT'(rd_en_q);
    ld_vld     = 1'b0;
    ld_dat     = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_FETCH;
          busy_d     = 1'b1;
          rd_en_d    = 1'b1;
          addr_d     = '0;
          left_d     = LW'(BYTE_CNT);
          hold_vld_d = 1'b0;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (rvld) begin
          ld_vld   = 1'b1;
          ld_dat   = ram_rdata;
          left_d   = left_q - LW'(1);
          pf_req_d = (left_q > LW'(1));
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (pf_req_q) begin
          rd_en_d = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
        end
        if (rvld) begin
          hold_d     = ram_rdata;
          hold_vld_d = 1'b1;
        end
        if (hold_vld_q && ld_rdy) begin
          ld_vld     = 1'b1;
          hold_vld_d = 1'b0;
          left_d     = left_q - LW'(1);
          pf_req_d   = (left_q > LW'(1));
        end else if (frame_end && left_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_DONE: state_d = ST_HOLD;
      ST_HOLD: begin
        // A level start left high after completion must not retrigger.
        if (!start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      left_q     <= '0;
      pf_req_q   <= 1'b0;
      hold_q     <= 8'd0;
      hold_vld_q <= 1'b0;
      rpipe_q    <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      left_q     <= left_d;
      pf_req_q   <= pf_req_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      rpipe_q    <= rpipe_d;
    end
  end

  uart_tx_shift #(.CPB(CPB)) u_shift (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .ld_vld    (ld_vld),
    .ld_dat    (ld_dat),
    .ld_rdy    (ld_rdy),
    .frame_end (frame_end),
    .txd       (uart_txd)
  );

  assign ram_rd_en = rd_en_q;
  assign ram_addr  = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ram_to_uart_tx.sv
// Bench for ram_to_uart_tx: four instances (1 byte, 4 bytes, RD_LAT=2, random 64-byte image at CPB=8).
// "Cycle k" means the value present at clock edge k, where edge 0 is the first edge that sees start high.
module tb_ram_to_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: CPB=10, 4 bytes
  logic start_a = 1'b0, rd_en_a, txd_a, busy_a, done_a;
  logic [3:0] addr_a;
  logic [7:0] rdata_a = 8'd0;
  logic [7:0] mem_a [16];
  // Instance B: CPB=10, 1 byte
  logic start_b = 1'b0, rd_en_b, txd_b, busy_b, done_b;
  logic [3:0] addr_b;
  logic [7:0] rdata_b = 8'd0;
  logic [7:0] mem_b [16];
  // Instance C: CPB=10, 2 bytes, two-cycle RAM
  logic start_c = 1'b0, rd_en_c, txd_c, busy_c, done_c;
  logic [3:0] addr_c;
  logic [7:0] rdata_c = 8'd0, r1_c = 8'd0;
  logic [7:0] mem_c [16];
  // Instance D: 1 MHz / 115200 baud truncates to 8 clocks per bit, 64 bytes fill the address space
  logic start_d = 1'b0, rd_en_d, txd_d, busy_d, done_d;
  logic [5:0] addr_d;
  logic [7:0] rdata_d = 8'd0;
  logic [7:0] mem_d [64];
  logic line_d [0:5199];

  logic [7:0] ref_img [64];

  ram_to_uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .ADDR_W(4), .BYTE_CNT(4), .RD_LAT(1)) dut_a (
    .sys_clk(clk), .sys_rst(rst), .start(start_a), .ram_rd_en(rd_en_a), .ram_addr(addr_a),
    .ram_rdata(rdata_a), .uart_txd(txd_a), .busy(busy_a), .done(done_a));
  ram_to_uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .ADDR_W(4), .BYTE_CNT(1), .RD_LAT(1)) dut_b (
    .sys_clk(clk), .sys_rst(rst), .start(start_b), .ram_rd_en(rd_en_b), .ram_addr(addr_b),
    .ram_rdata(rdata_b), .uart_txd(txd_b), .busy(busy_b), .done(done_b));
  ram_to_uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .ADDR_W(4), .BYTE_CNT(2), .RD_LAT(2)) dut_c (
    .sys_clk(clk), .sys_rst(rst), .start(start_c), .ram_rd_en(rd_en_c), .ram_addr(addr_c),
    .ram_rdata(rdata_c), .uart_txd(txd_c), .busy(busy_c), .done(done_c));
  ram_to_uart_tx #(.CLK_FREQ(1_000_000), .BAUD(115_200), .ADDR_W(6), .BYTE_CNT(64), .RD_LAT(1)) dut_d (
    .sys_clk(clk), .sys_rst(rst), .start(start_d), .ram_rd_en(rd_en_d), .ram_addr(addr_d),
    .ram_rdata(rdata_d), .uart_txd(txd_d), .busy(busy_d), .done(done_d));

  always @(posedge clk) if (rd_en_a) rdata_a <= mem_a[addr_a];
  always @(posedge clk) if (rd_en_b) rdata_b <= mem_b[addr_b];
  always @(posedge clk) begin
    if (rd_en_c) r1_c <= mem_c[addr_c];
    rdata_c <= r1_c;
  end
  always @(posedge clk) if (rd_en_d) rdata_d <= mem_d[addr_d];

  // Ideal line level at cycle k for n back-to-back frames of ref_img starting at cycle first.
  function automatic logic exp_txd(input int k, input int first, input int cpb, input int n);
    int off, fr, b;
    if (k < first) return 1'b1;
    off = k - first;
    fr  = off / (10 * cpb);
    if (fr >= n) return 1'b1;
    b = (off % (10 * cpb)) / cpb;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return ref_img[fr][b-1];
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if ({txd_a, busy_a, done_a, rd_en_a} !== 4'b1000 || addr_a !== 4'd0) begin
      errors++; $display("FAIL reset_a got txd/busy/done/rd=%b addr=%0d want 1000 addr=0", {txd_a, busy_a, done_a, rd_en_a}, addr_a); end
    checks++; if ({txd_b, busy_b, done_b, rd_en_b} !== 4'b1000 || addr_b !== 4'd0) begin
      errors++; $display("FAIL reset_b got txd/busy/done/rd=%b addr=%0d want 1000 addr=0", {txd_b, busy_b, done_b, rd_en_b}, addr_b); end
    checks++; if ({txd_c, busy_c, done_c, rd_en_c} !== 4'b1000 || addr_c !== 4'd0) begin
      errors++; $display("FAIL reset_c got txd/busy/done/rd=%b addr=%0d want 1000 addr=0", {txd_c, busy_c, done_c, rd_en_c}, addr_c); end
    checks++; if ({txd_d, busy_d, done_d, rd_en_d} !== 4'b1000 || addr_d !== 6'd0) begin
      errors++; $display("FAIL reset_d got txd/busy/done/rd=%b addr=%0d want 1000 addr=0", {txd_d, busy_d, done_d, rd_en_d}, addr_d); end
    rst = 1'b0;
  endtask

  task automatic test_single_byte();
    int rdk[$];
    logic e;
    mem_b[0] = 8'hA5;
    ref_img[0] = 8'hA5;
    @(negedge clk); start_b = 1'b1;
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      e = exp_txd(k, 3, 10, 1);
      checks++; if (txd_b !== e) begin errors++; $display("FAIL single_txd cycle %0d got %b want %b", k, txd_b, e); end
      checks++; if (busy_b !== (k < 103)) begin errors++; $display("FAIL single_busy cycle %0d got %b want %b", k, busy_b, k < 103); end
      checks++; if (done_b !== (k == 103)) begin errors++; $display("FAIL single_done cycle %0d got %b want %b", k, done_b, k == 103); end
      if (rd_en_b === 1'b1) rdk.push_back(k);
      if (k == 104) start_b = 1'b0;
    end
    checks++; if (rdk.size() != 1 || rdk[0] != 1 || addr_b !== 4'd0) begin
      errors++; $display("FAIL single_reads got count=%0d addr=%0d want one read at cycle 1 addr=0", rdk.size(), addr_b); end
  endtask

  // One complete 4-byte transfer on instance A from an idle DUT, with start dropped at drop_at (0 = keep).
  task automatic test_full_transfer_a(input string tag, input int drop_at);
    int rdk[$];
    int rda[$];
    logic e;
    @(negedge clk); start_a = 1'b1;
    for (int k = 1; k <= 406; k++) begin
      @(negedge clk);
      e = exp_txd(k, 3, 10, 4);
      checks++; if (txd_a !== e) begin errors++; $display("FAIL %s_txd cycle %0d got %b want %b", tag, k, txd_a, e); end
      checks++; if (busy_a !== (k < 403)) begin errors++; $display("FAIL %s_busy cycle %0d got %b want %b", tag, k, busy_a, k < 403); end
      checks++; if (done_a !== (k == 403)) begin errors++; $display("FAIL %s_done cycle %0d got %b want %b", tag, k, done_a, k == 403); end
      if (rd_en_a === 1'b1) begin rdk.push_back(k); rda.push_back(int'(addr_a)); end
      if (k == drop_at) start_a = 1'b0;
    end
    checks++;
    if (rdk.size() != 4) begin
      errors++; $display("FAIL %s_read_count got %0d want 4", tag, rdk.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (rda[i] != i || rdk[i] != ((i == 0) ? 1 : 4 + 100 * (i - 1))) begin
          errors++; $display("FAIL %s_read%0d got addr %0d at cycle %0d want addr %0d at cycle %0d",
                             tag, i, rda[i], rdk[i], i, (i == 0) ? 1 : 4 + 100 * (i - 1)); end
      end
    end
    checks++; if (addr_a !== 4'd3) begin errors++; $display("FAIL %s_addr_after got %0d want 3", tag, addr_a); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] img [4] = '{8'h00, 8'hFF, 8'h55, 8'h80};
    for (int i = 0; i < 4; i++) begin mem_a[i] = img[i]; ref_img[i] = img[i]; end
    test_full_transfer_a("b2b", 50);
  endtask

  task automatic test_reset_midframe();
    logic e;
    @(negedge clk); start_a = 1'b1;
    for (int k = 1; k <= 227; k++) @(negedge clk);
    e = exp_txd(227, 3, 10, 4);
    checks++; if (txd_a !== e) begin errors++; $display("FAIL midrst_pre_txd got %b want %b", txd_a, e); end
    rst = 1'b1;
    #1;
    checks++; if ({txd_a, busy_a, done_a, rd_en_a} !== 4'b1000 || addr_a !== 4'd0) begin
      errors++; $display("FAIL midrst_async got txd/busy/done/rd=%b addr=%0d want 1000 addr=0", {txd_a, busy_a, done_a, rd_en_a}, addr_a); end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++; if (busy_a !== 1'b0 || rd_en_a !== 1'b0) begin
        errors++; $display("FAIL midrst_start_ignored got busy=%b rd_en=%b want 0 0", busy_a, rd_en_a); end
    end
    rst = 1'b0;
    start_a = 1'b0;
    test_full_transfer_a("restart", 404);
  endtask

  task automatic test_start_held();
    test_full_transfer_a("held1", 0);
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      checks++; if ({txd_a, busy_a, done_a, rd_en_a} !== 4'b1000) begin
        errors++; $display("FAIL held_no_retrigger got txd/busy/done/rd=%b want 1000", {txd_a, busy_a, done_a, rd_en_a}); end
    end
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    test_full_transfer_a("held2", 404);
  endtask

  task automatic test_rd_latency();
    int rdk[$];
    int rda[$];
    logic e;
    mem_c[0] = 8'h3C; mem_c[1] = 8'hC3;
    ref_img[0] = 8'h3C; ref_img[1] = 8'hC3;
    @(negedge clk); start_c = 1'b1;
    for (int k = 1; k <= 210; k++) begin
      @(negedge clk);
      e = exp_txd(k, 4, 10, 2);
      checks++; if (txd_c !== e) begin errors++; $display("FAIL lat2_txd cycle %0d got %b want %b", k, txd_c, e); end
      checks++; if (busy_c !== (k < 204)) begin errors++; $display("FAIL lat2_busy cycle %0d got %b want %b", k, busy_c, k < 204); end
      checks++; if (done_c !== (k == 204)) begin errors++; $display("FAIL lat2_done cycle %0d got %b want %b", k, done_c, k == 204); end
      if (rd_en_c === 1'b1) begin rdk.push_back(k); rda.push_back(int'(addr_c)); end
      if (k == 205) start_c = 1'b0;
    end
    checks++; if (rdk.size() != 2 || rda[0] != 0 || rda[1] != 1 || rdk[0] != 1 || rdk[1] != 5) begin
      errors++; $display("FAIL lat2_reads got %0d reads want addr 0 at cycle 1 and addr 1 at cycle 5", rdk.size()); end
  endtask

  task automatic test_random_image();
    int nrd = 0;
    int p = 1;
    int m;
    logic [7:0] got;
    for (int i = 0; i < 64; i++) mem_d[i] = 8'($urandom_range(0, 255));
    line_d[0] = 1'b1;
    @(negedge clk); start_d = 1'b1;
    for (int k = 1; k <= 5130; k++) begin
      @(negedge clk);
      line_d[k] = txd_d;
      checks++; if (done_d !== (k == 5123)) begin errors++; $display("FAIL img_done cycle %0d got %b want %b", k, done_d, k == 5123); end
      if (rd_en_d === 1'b1) nrd++;
      if (k == 5124) start_d = 1'b0;
    end
    for (int k = 5131; k < 5200; k++) line_d[k] = 1'b1;
    checks++; if (nrd != 64 || addr_d !== 6'd63) begin
      errors++; $display("FAIL img_reads got %0d reads last addr %0d want 64 reads last addr 63", nrd, addr_d); end
    // Receiver: find each falling edge, sample mid-bit, check stop bit and frame spacing.
    for (int nb = 0; nb < 64; nb++) begin
      while (p <= 5130 && line_d[p] !== 1'b0) p++;
      checks++;
      if (p > 5130) begin
        errors++; $display("FAIL img_rx_timeout byte %0d got no start bit want start at cycle %0d", nb, 3 + 80 * nb);
        break;
      end
      if (p != 3 + 80 * nb) begin errors++; $display("FAIL img_start_pos byte %0d got cycle %0d want %0d", nb, p, 3 + 80 * nb); end
      m = p + 4;
      for (int b = 0; b < 8; b++) got[b] = line_d[m + 8 * (b + 1)];
      checks++; if (got !== mem_d[nb]) begin errors++; $display("FAIL img_byte %0d got %h want %h", nb, got, mem_d[nb]); end
      checks++; if (line_d[m + 72] !== 1'b1) begin errors++; $display("FAIL img_stop byte %0d got %b want 1", nb, line_d[m + 72]); end
      p = m + 72;
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_reset_midframe();
    test_start_held();
    test_rd_latency();
    test_random_image();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
